// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, hold-level encodings and helpers for the pipeline control slice.
package pipe_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int HOLD_W      = 3;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [HOLD_W-1:0]      hold_flag_t;

  localparam hold_flag_t HOLD_NONE = 3'd0;
  localparam hold_flag_t HOLD_PC   = 3'd1;
  localparam hold_flag_t HOLD_IF   = 3'd2;
  localparam hold_flag_t HOLD_ID   = 3'd3;

  // Hold levels are ordered: the deepest requested hold wins.
  function automatic hold_flag_t hold_max(input hold_flag_t a, input hold_flag_t b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the pipeline control unit.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             jump_flag_i;
  inst_addr_t       jump_addr_i;
  logic             hold_ex_i;
  logic             hold_bus_i;
  logic             int_req_i;
  inst_addr_t       int_addr_i;
  hold_flag_t       hold_flag_o;
  logic             jump_flag_o;
  inst_addr_t       jump_addr_o;
  logic             int_ack_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, int_req_i, int_addr_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, int_req_i, int_addr_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges EX/bus stalls with jump and interrupt redirects,
// defers redirects across bus stalls, stretches flushes and counts events.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave ctrl
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [3:0] FCNT_INIT   = 4'(FLUSH_CYCLES - 1);
  localparam logic [1:0] REDIR_STATE = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  logic [1:0]       state_r, nxt_state_s;
  logic [3:0]       fcnt_r, nxt_fcnt_s;
  inst_addr_t       pend_addr_r, nxt_pend_addr_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  hold_flag_t       req_hold_s, hold_s;
  logic             redirect_s, ack_s;
  inst_addr_t       redirect_addr_s;

  // Next-state decode and the redirect/hold request of the current cycle.
  always_comb begin
    nxt_state_s     = state_r;
    nxt_fcnt_s      = fcnt_r;
    nxt_pend_addr_s = pend_addr_r;
    req_hold_s      = HOLD_NONE;
    redirect_s      = 1'b0;
    redirect_addr_s = {INST_ADDR_W{1'b0}};
    ack_s           = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ctrl.jump_flag_i) begin
          req_hold_s = HOLD_ID;
          if (ctrl.hold_bus_i) begin
            // pc_reg would drop the redirect under a bus hold, so park it.
            nxt_pend_addr_s = ctrl.jump_addr_i;
            nxt_state_s     = ST_PEND;
          end else begin
            redirect_s      = 1'b1;
            redirect_addr_s = ctrl.jump_addr_i;
            nxt_fcnt_s      = FCNT_INIT;
            nxt_state_s     = REDIR_STATE;
          end
        end else if (ctrl.int_req_i && !ctrl.hold_ex_i && !ctrl.hold_bus_i) begin
          req_hold_s      = HOLD_ID;
          ack_s           = 1'b1;
          redirect_s      = 1'b1;
          redirect_addr_s = ctrl.int_addr_i;
          nxt_fcnt_s      = FCNT_INIT;
          nxt_state_s     = REDIR_STATE;
        end else begin
          req_hold_s = HOLD_NONE;
        end
      end
      ST_PEND: begin
        req_hold_s = HOLD_ID;
        if (!ctrl.hold_bus_i) begin
          redirect_s      = 1'b1;
          redirect_addr_s = pend_addr_r;
          nxt_fcnt_s      = FCNT_INIT;
          nxt_state_s     = REDIR_STATE;
        end else begin
          nxt_state_s = ST_PEND;
        end
      end
      ST_FLUSH: begin
        // The redirect cycle itself is the first flush cycle.
        req_hold_s = HOLD_ID;
        nxt_fcnt_s = fcnt_r - 4'd1;
        if (fcnt_r <= 4'd1) begin
          nxt_state_s = ST_RUN;
        end else begin
          nxt_state_s = ST_FLUSH;
        end
      end
      default: begin
        nxt_state_s = ST_RUN;
        nxt_fcnt_s  = 4'd0;
      end
    endcase
  end

  // Deepest of the redirect, EX and bus hold requests.
  always_comb begin
    hold_s = hold_max(req_hold_s,
                      hold_max(ctrl.hold_bus_i ? HOLD_PC : HOLD_NONE,
                               ctrl.hold_ex_i  ? HOLD_ID : HOLD_NONE));
  end

  // Zero-latency control outputs, quiet while reset is applied.
  always_comb begin
    if (rst) begin
      ctrl.hold_flag_o = HOLD_NONE;
      ctrl.jump_flag_o = 1'b0;
      ctrl.jump_addr_o = {INST_ADDR_W{1'b0}};
      ctrl.int_ack_o   = 1'b0;
    end else begin
      ctrl.hold_flag_o = hold_s;
      ctrl.jump_flag_o = redirect_s;
      ctrl.jump_addr_o = redirect_addr_s;
      ctrl.int_ack_o   = ack_s;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      fcnt_r      <= 4'd0;
      pend_addr_r <= {INST_ADDR_W{1'b0}};
    end else begin
      state_r     <= nxt_state_s;
      fcnt_r      <= nxt_fcnt_s;
      pend_addr_r <= nxt_pend_addr_s;
    end
  end

  // Stall cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hold_s != HOLD_NONE) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Redirect counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (redirect_s) begin
      flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  assign ctrl.stall_cnt_o = stall_cnt_r;
  assign ctrl.flush_cnt_o = flush_cnt_r;

endmodule
